// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: ALU and load queues share one
// registered write port, memory has priority unless the ALU has starved.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 write_back,
    output logic [ADDR_W-1:0]    write_addr,
    output logic [DATA_W-1:0]    write_data,
    output logic                 grant_mem,
    output logic [2**ADDR_W-1:0] busy_mask
);

    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SC_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  STARVE_C = SC_W'(STARVE_LIMIT);

    logic [ADDR_W-1:0] alu_addr_q [DEPTH];
    logic [DATA_W-1:0] alu_data_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0] alu_rd, alu_wr, mem_rd, mem_wr;
    logic [CNT_W-1:0] alu_cnt, mem_cnt;
    logic [SC_W-1:0]  starve_cnt;

    logic alu_push, mem_push, alu_pop, mem_pop, alu_ne, mem_ne;

    // Ready looks only at occupancy, so a full queue refuses even while popping.
    assign alu_ready = (alu_cnt < DEPTH_C) && !reset;
    assign mem_ready = (mem_cnt < DEPTH_C) && !reset;
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    assign alu_ne  = (alu_cnt != '0);
    assign mem_ne  = (mem_cnt != '0);
    assign alu_pop = alu_ne && (!mem_ne || (starve_cnt == STARVE_C));
    assign mem_pop = mem_ne && !alu_pop;

    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_addr_q[alu_wr] <= alu_addr;
            alu_data_q[alu_wr] <= alu_data;
        end
        if (mem_push) begin
            mem_addr_q[mem_wr] <= mem_addr;
            mem_data_q[mem_wr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_rd     <= '0;
            alu_wr     <= '0;
            alu_cnt    <= '0;
            mem_rd     <= '0;
            mem_wr     <= '0;
            mem_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            if (alu_push) alu_wr <= alu_wr + PTR_W'(1);
            if (alu_pop)  alu_rd <= alu_rd + PTR_W'(1);
            if (mem_push) mem_wr <= mem_wr + PTR_W'(1);
            if (mem_pop)  mem_rd <= mem_rd + PTR_W'(1);
            alu_cnt <= alu_cnt + CNT_W'(alu_push) - CNT_W'(alu_pop);
            mem_cnt <= mem_cnt + CNT_W'(mem_push) - CNT_W'(mem_pop);
            if (!alu_ne || alu_pop)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_C)
                starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_back <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            grant_mem  <= 1'b0;
        end else if (alu_pop) begin
            write_back <= 1'b1;
            write_addr <= alu_addr_q[alu_rd];
            write_data <= alu_data_q[alu_rd];
            grant_mem  <= 1'b0;
        end else if (mem_pop) begin
            write_back <= 1'b1;
            write_addr <= mem_addr_q[mem_rd];
            write_data <= mem_data_q[mem_rd];
            grant_mem  <= 1'b1;
        end else begin
            write_back <= 1'b0;
        end
    end

    // Walk each queue from its head; slot i is live when i < count.
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < alu_cnt)
                busy_mask[alu_addr_q[alu_rd + PTR_W'(i)]] = 1'b1;
            if (CNT_W'(i) < mem_cnt)
                busy_mask[mem_addr_q[mem_rd + PTR_W'(i)]] = 1'b1;
        end
        if (write_back)
            busy_mask[write_addr] = 1'b1;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port arbiter for the 8x16 register file. Two producers compete for the single register-file write port: the ALU result path and the memory-load path. Each producer has its own small queue. The block drives write_back, write_addr and write_data to the register file. It also exports a pending-write mask that the hazard/stall logic uses.

Parameters:
DATA_W, 16, write data width
ADDR_W, 3, register address width (2**ADDR_W registers)
DEPTH, 2, entries per requester queue (power of 2, >=2)
STARVE_LIMIT, 3, consecutive lost cycles after which ALU overrides memory priority

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
alu_valid  in  1  ALU write request
alu_ready  out  1  ALU queue can accept
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load write request
mem_ready  out  1  load queue can accept
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
write_back  out  1  register-file write enable (registered)
write_addr  out  ADDR_W  register-file write address (registered)
write_data  out  DATA_W  register-file write data (registered)
grant_mem  out  1  current write_back originates from memory queue (registered)
busy_mask  out  2**ADDR_W  bit i = a write to register i is queued or on the output

Behaviour:
- Reset (synchronous, active-high): both queues emptied; starvation counter = 0; write_back = 0, write_addr = 0, write_data = 0, grant_mem = 0. While reset is high, alu_ready = mem_ready = 0 and inputs are ignored.
- Reset asserted mid-operation discards all queued entries. No write is emitted for them. busy_mask = 0 from the cycle after reset is sampled.
- Handshake: a push happens when valid && ready at posedge. ready = (count < DEPTH) && !reset. Ready does not depend on valid or on same-cycle pops. A full queue refuses a push even in a cycle where it pops.
- Queues are FIFO with wrap-around pointers and a count of 0..DEPTH. Order within one requester is preserved.
- Arbitration is evaluated every cycle on the queue state before the edge:
  - Neither queue non-empty: no pop.
  - Only one queue non-empty: that queue pops.
  - Both non-empty: memory wins, unless starve_cnt == STARVE_LIMIT, in which case ALU wins.
- Starvation counter: increments when the ALU queue is non-empty and ALU is not granted. Resets to 0 when ALU is granted or the ALU queue is empty. Saturates at STARVE_LIMIT.
- Output register, loaded at the same edge as the pop:
  - write_back = 1, write_addr/write_data = popped head, grant_mem = source.
  - No pop: write_back = 0; write_addr/write_data hold their last values.
- Latency: a request accepted at edge N is popped no earlier than edge N+1. write_back is high during cycle N+1..N+2, and the register file captures it on that cycle's negedge. No same-cycle bypass from input to output.
- Throughput: one register-file write per cycle in total.
- busy_mask: combinational OR of the decoded addresses of all valid entries in both queues, plus write_addr when write_back = 1.
- Ordering: there is no ordering guarantee across requesters for the same register. The pipeline must not issue such pairs, and the hazard logic uses busy_mask to stall them.
- Simultaneous push and pop on the same queue in one cycle (count < DEPTH): both happen and count is unchanged.

Test Plan:
- Reset, then single ALU push (addr 3, data 0x1234) at edge 1 -> write_back = 1, write_addr = 3, write_data = 0x1234, grant_mem = 0 in the cycle after edge 2. busy_mask = 0x08 from edge 1 until write_back drops.
- ALU and memory push in the same cycle (ALU r1 = 0xAAAA, mem r2 = 0x5555) -> memory write first (grant_mem = 1, r2), ALU write the next cycle (r1). One write per cycle.
- Memory streams continuously while ALU holds one entry, STARVE_LIMIT = 3 -> ALU loses 3 cycles, then is granted on the 4th contested cycle. Counter returns to 0 after the grant.
- Fill the ALU queue to DEPTH = 2 while memory is kept busy -> alu_ready = 0. A third push with alu_valid = 1 is not accepted and not lost. alu_ready = 1 the cycle after the first ALU pop.
- Queue 2 memory entries and 1 ALU entry, assert reset for 1 cycle -> no further write_back pulses. busy_mask = 0, both readys = 0 during reset and 1 after.
- Pointer wrap: push and pop the memory queue 5 times back to back (data 1..5) -> write_data sequence 1, 2, 3, 4, 5 with no gaps after the first write.
